// File: rtl/lcd_hex_writer.sv
// lcd_hex_writer: shows two 32-bit words as 8 uppercase hex characters each on
// a 16x2 HD44780 character LCD. Handles power-up delay, the init command
// sequence, the EN strobe and the inter-byte waits. Refresh requests that
// arrive while a transfer is in progress are merged into one follow-up refresh.
module lcd_hex_writer #(
   parameter int EN_PULSE_CYCLES     = 25,
   parameter int CMD_WAIT_CYCLES     = 2500,
   parameter int CLEAR_WAIT_CYCLES   = 100000,
   parameter int POWERUP_WAIT_CYCLES = 1000000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [31:0] data_line1,
   input  logic [31:0] data_line2,
   input  logic        update,
   output logic        busy,
   output logic        LCD_RS,
   output logic        LCD_RW,
   output logic        LCD_EN,
   output logic [7:0]  LCD_DATA
);

   // The counter must hold the largest reload value without wrapping.
   localparam int MAX_AB  = (EN_PULSE_CYCLES > CMD_WAIT_CYCLES) ? EN_PULSE_CYCLES : CMD_WAIT_CYCLES;
   localparam int MAX_CD  = (CLEAR_WAIT_CYCLES > POWERUP_WAIT_CYCLES) ? CLEAR_WAIT_CYCLES : POWERUP_WAIT_CYCLES;
   localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   // Reload values: each phase counts down to zero, so load N-1 for N cycles.
   localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(EN_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] PU_LOAD    = CNT_W'(POWERUP_WAIT_CYCLES - 1);

   // Index of the final byte in each sequence.
   localparam logic [4:0] INIT_LAST    = 5'd3;
   localparam logic [4:0] REFRESH_LAST = 5'd17;

   typedef enum logic [1:0] {
      ST_POWERUP,
      ST_INIT,
      ST_IDLE,
      ST_REFRESH
   } state_t;

   // Sub-phases of one byte transfer.
   typedef enum logic [1:0] {
      PH_SETUP,
      PH_PULSE,
      PH_HOLD
   } phase_t;

   state_t           state_q, state_d;
   phase_t           phase_q, phase_d;
   logic [4:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic [31:0]      snap1_q, snap1_d;
   logic [31:0]      snap2_q, snap2_d;
   logic             en_q, en_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             busy_q, busy_d;

   // Byte tables: {rs, byte} for each position of the init and refresh streams.
   logic [8:0]       init_tbl    [4];
   logic [8:0]       refresh_tbl [18];

   // Lookup of the byte that would be sent next.
   logic [4:0]       nxt_idx;
   logic             nxt_refresh;
   logic [8:0]       nxt_byte;

   logic             load_byte;
   logic             is_clear;
   logic [4:0]       last_idx;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

   assign init_tbl[0] = {1'b0, 8'h38};   // 8-bit bus, 2 lines, 5x8 font
   assign init_tbl[1] = {1'b0, 8'h0C};   // display on, cursor off
   assign init_tbl[2] = {1'b0, 8'h01};   // clear display
   assign init_tbl[3] = {1'b0, 8'h06};   // entry mode: increment, no shift

   assign refresh_tbl[0] = {1'b0, 8'h80};  // DDRAM address: line 1, column 0
   assign refresh_tbl[9] = {1'b0, 8'hC0};  // DDRAM address: line 2, column 0

   // Characters come from the snapshot, most significant nibble first.
   for (genvar gi = 0; gi < 8; gi++) begin : g_chars
      assign refresh_tbl[1 + gi]  = {1'b1, hex_ascii(snap1_q[31 - 4*gi -: 4])};
      assign refresh_tbl[10 + gi] = {1'b1, hex_ascii(snap2_q[31 - 4*gi -: 4])};
   end

   // Pick the byte following the current one (or the first byte of a new stream).
   always_comb begin
      nxt_idx     = 5'd0;
      nxt_refresh = (state_q == ST_IDLE) || (state_q == ST_REFRESH);
      if ((state_q == ST_INIT) || (state_q == ST_REFRESH)) begin
         nxt_idx = idx_q + 5'd1;
      end
      if (nxt_refresh) begin
         nxt_byte = refresh_tbl[nxt_idx];
      end else begin
         nxt_byte = init_tbl[nxt_idx[1:0]];
      end
   end

   // The clear command needs the long wait; character data can never be 0x01.
   assign is_clear = !rs_q && (data_q == 8'h01);
   assign last_idx = (state_q == ST_INIT) ? INIT_LAST : REFRESH_LAST;

   // Next-state logic: sequence control, counters, snapshot and pending merge.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      snap1_d   = snap1_q;
      snap2_d   = snap2_q;
      load_byte = 1'b0;

      case (state_q)
         ST_POWERUP: begin
            if (cnt_q == '0) begin
               state_d   = ST_INIT;
               phase_d   = PH_SETUP;
               load_byte = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_IDLE: begin
            if (update || pending_q) begin
               state_d   = ST_REFRESH;
               phase_d   = PH_SETUP;
               snap1_d   = data_line1;
               snap2_d   = data_line2;
               pending_d = 1'b0;
               load_byte = 1'b1;
            end
         end

         ST_INIT, ST_REFRESH: begin
            case (phase_q)
               PH_SETUP: begin
                  phase_d = PH_PULSE;
                  cnt_d   = EN_LOAD;
               end
               PH_PULSE: begin
                  if (cnt_q == '0) begin
                     phase_d = PH_HOLD;
                     cnt_d   = is_clear ? CLEAR_LOAD : CMD_LOAD;
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
               PH_HOLD: begin
                  if (cnt_q == '0) begin
                     if (idx_q == last_idx) begin
                        state_d = ST_IDLE;
                     end else begin
                        phase_d   = PH_SETUP;
                        load_byte = 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
               default: begin
                  phase_d = PH_SETUP;
               end
            endcase
         end

         default: begin
            state_d = ST_POWERUP;
            cnt_d   = PU_LOAD;
         end
      endcase

      // Requests while busy collapse into a single follow-up refresh.
      if (update && (state_q != ST_IDLE)) begin
         pending_d = 1'b1;
      end

      if (load_byte) begin
         idx_d = nxt_idx;
      end
   end

   // Output values for the next cycle; RS/DATA only change when a byte is loaded.
   always_comb begin
      rs_d   = rs_q;
      data_d = data_q;
      if (load_byte) begin
         rs_d   = nxt_byte[8];
         data_d = nxt_byte[7:0];
      end
      busy_d = (state_d != ST_IDLE);
      en_d   = (phase_d == PH_PULSE) && ((state_d == ST_INIT) || (state_d == ST_REFRESH));
   end

   // State and output registers; reset abandons any transfer and drops EN at once.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q   <= ST_POWERUP;
         phase_q   <= PH_SETUP;
         idx_q     <= 5'd0;
         cnt_q     <= PU_LOAD;
         pending_q <= 1'b0;
         snap1_q   <= 32'h0;
         snap2_q   <= 32'h0;
         en_q      <= 1'b0;
         rs_q      <= 1'b0;
         data_q    <= 8'h00;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         snap1_q   <= snap1_d;
         snap2_q   <= snap2_d;
         en_q      <= en_d;
         rs_q      <= rs_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign LCD_EN   = en_q;
   assign LCD_RS   = rs_q;
   assign LCD_DATA = data_q;
   assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Testbench for lcd_hex_writer: scoreboard of expected LCD bytes, checked on
// every EN rising edge, plus timing checks on busy, EN width and EN gaps.
module tb_lcd_hex_writer;

   logic        clk;
   logic        rst;
   logic [31:0] data_line1;
   logic [31:0] data_line2;
   logic        update;
   logic        busy;
   logic        lcd_rs;
   logic        lcd_rw;
   logic        lcd_en;
   logic [7:0]  lcd_data;

   typedef struct {
      logic [8:0] val;
      int         gap;
   } exp_t;

   exp_t sb [$];

   int checks_cnt = 0;
   int errors_cnt = 0;

   // monitor state
   logic       prev_en = 1'b0;
   int         width   = 0;
   int         low_cnt = 0;
   logic [8:0] captured;
   logic [8:0] cur;
   exp_t       e;

   lcd_hex_writer #(
      .EN_PULSE_CYCLES    (2),
      .CMD_WAIT_CYCLES    (4),
      .CLEAR_WAIT_CYCLES  (8),
      .POWERUP_WAIT_CYCLES(10)
   ) dut (
      .CLOCK_50  (clk),
      .reset     (rst),
      .data_line1(data_line1),
      .data_line2(data_line2),
      .update    (update),
      .busy      (busy),
      .LCD_RS    (lcd_rs),
      .LCD_RW    (lcd_rw),
      .LCD_EN    (lcd_en),
      .LCD_DATA  (lcd_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [8:0] v, input int g);
      exp_t x;
      x.val = v;
      x.gap = g;
      sb.push_back(x);
   endtask

   task automatic push_init();
      push_exp({1'b0, 8'h38}, -1);
      push_exp({1'b0, 8'h0C}, 5);
      push_exp({1'b0, 8'h01}, 5);
      push_exp({1'b0, 8'h06}, 9);
   endtask

   task automatic push_refresh(input logic [31:0] l1, input logic [31:0] l2);
      string      hexs;
      logic [3:0] nib;
      hexs = "0123456789ABCDEF";
      push_exp({1'b0, 8'h80}, -1);
      for (int k = 0; k < 8; k++) begin
         nib = l1[31 - 4*k -: 4];
         push_exp({1'b1, hexs[nib]}, 5);
      end
      push_exp({1'b0, 8'hC0}, 5);
      for (int k = 0; k < 8; k++) begin
         nib = l2[31 - 4*k -: 4];
         push_exp({1'b1, hexs[nib]}, 5);
      end
   endtask

   // Count rising edges until busy is seen low (bounded).
   task automatic wait_idle(output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (busy && n < 1000);
   endtask

   // Byte monitor: one line per strobed byte, compared against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         prev_en = 1'b0;
         width   = 0;
         low_cnt = 0;
      end else begin
         cur = {lcd_rs, lcd_data};
         if (lcd_en && !prev_en) begin
            $display("pulse rs=%0d data=%02h", lcd_rs, lcd_data);
            if (sb.size() == 0) begin
               check_eq("unexpected_pulse", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               check_eq("byte", 32'(cur), 32'(e.val));
               if (e.gap >= 0) check_eq("en_gap", 32'(low_cnt), 32'(e.gap));
            end
            captured = cur;
            width    = 1;
         end else if (lcd_en) begin
            width++;
         end else if (prev_en) begin
            check_eq("en_width", 32'(width), 32'd2);
            check_eq("hold_stable", 32'(cur), 32'(captured));
            low_cnt = 1;
         end else begin
            low_cnt++;
         end
         prev_en = lcd_en;
      end
   end

   int n;
   int rises;
   logic p;

   initial begin
      rst        = 1'b1;
      update     = 1'b0;
      data_line1 = 32'h0;
      data_line2 = 32'h0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_en", 32'(lcd_en), 32'd0);
      check_eq("rst_rs", 32'(lcd_rs), 32'd0);
      check_eq("rst_rw", 32'(lcd_rw), 32'd0);
      check_eq("rst_data", 32'(lcd_data), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd1);

      // 1: power-up and init
      rst = 1'b0;
      push_init();
      wait_idle(n);
      check_eq("init_cycles", 32'(n), 32'd42);
      check_eq("init_drained", 32'(sb.size()), 32'd0);

      // 2: plain refresh
      data_line1 = 32'h0123ABCF;
      data_line2 = 32'hDEADBEEF;
      update = 1'b1;
      push_refresh(data_line1, data_line2);
      @(posedge clk);
      #1;
      update = 1'b0;
      wait_idle(n);
      check_eq("refresh_busy_cycles", 32'(n), 32'd126);
      check_eq("refresh_drained", 32'(sb.size()), 32'd0);
      check_eq("rw_low", 32'(lcd_rw), 32'd0);

      // 3: input change mid-refresh must not affect the snapshot
      data_line1 = 32'h13579BDF;
      data_line2 = 32'h2468ACE0;
      update = 1'b1;
      push_refresh(data_line1, data_line2);
      @(posedge clk);
      #1;
      update = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      data_line1 = 32'hFFFFFFFF;
      wait_idle(n);
      check_eq("snap_busy_cycles", 32'(n), 32'd106);
      check_eq("snap_drained", 32'(sb.size()), 32'd0);

      // 4: three requests during a refresh merge into exactly one more
      data_line1 = 32'h89ABCDEF;
      data_line2 = 32'h01234567;
      update = 1'b1;
      push_refresh(data_line1, data_line2);
      @(posedge clk);
      #1;
      update = 1'b0;
      for (int k = 0; k < 3; k++) begin
         repeat (10) @(posedge clk);
         #1;
         update = 1'b1;
         @(posedge clk);
         #1;
         update = 1'b0;
      end
      data_line1 = 32'hCAFE0042;
      data_line2 = 32'h5A5AA5A5;
      push_refresh(data_line1, data_line2);
      wait_idle(n);
      check_eq("merge_first_end", 32'(n), 32'd93);
      @(posedge clk);
      #1;
      check_eq("merge_restart", 32'(busy), 32'd1);
      wait_idle(n);
      check_eq("merge_second_cycles", 32'(n), 32'd126);
      repeat (100) @(posedge clk);
      #1;
      check_eq("no_third_refresh", 32'(busy), 32'd0);
      check_eq("merge_drained", 32'(sb.size()), 32'd0);

      // 5: update during init starts a refresh right after init
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      push_init();
      repeat (15) @(posedge clk);
      #1;
      data_line1 = 32'h00FF10EF;
      data_line2 = 32'h9876FEDC;
      update = 1'b1;
      push_refresh(data_line1, data_line2);
      @(posedge clk);
      #1;
      update = 1'b0;
      wait_idle(n);
      check_eq("init2_end", 32'(n), 32'd26);
      @(posedge clk);
      #1;
      check_eq("post_init_refresh", 32'(busy), 32'd1);
      wait_idle(n);
      check_eq("post_init_cycles", 32'(n), 32'd126);
      check_eq("post_init_drained", 32'(sb.size()), 32'd0);

      // 6: reset while EN is high
      data_line1 = 32'h11223344;
      data_line2 = 32'h55667788;
      update = 1'b1;
      push_refresh(data_line1, data_line2);
      @(posedge clk);
      #1;
      update = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      update = 1'b1;
      @(posedge clk);
      #1;
      update = 1'b0;
      rises = 0;
      p = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (lcd_en && !p) rises++;
         p = lcd_en;
         if (rises == 5 && lcd_en) break;
      end
      check_eq("pulse_found", 32'(rises), 32'd5);
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_en_drop", 32'(lcd_en), 32'd0);
      check_eq("async_busy", 32'(busy), 32'd1);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      push_init();
      wait_idle(n);
      check_eq("reinit_cycles", 32'(n), 32'd42);
      repeat (100) @(posedge clk);
      #1;
      check_eq("pending_discarded", 32'(busy), 32'd0);
      check_eq("reinit_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
